requant_sched: RTL

Sequencer for the 16b→8b requantization path. Takes a per-burst layer config (shift, rounding mode, length), streams 16-bit signed accumulator words through one registered shift/round/saturate lane, and packs four 8-bit results per 32-bit output word. It sits between the accumulator drain and the activation write-back buffer, and provides valid/ready backpressure on both sides.

---
 rtl/requant_sched_pkg.sv | 38 +++
 rtl/requant_sched_if.sv | 36 +++
 rtl/requant_lane.sv | 39 +++
 rtl/requant_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/requant_sched_pkg.sv
// Shared constants, state encoding and the per-word requantization function for the
// 16b -> 8b requant sequencer.
package npu_requant_pkg;

    localparam int SAT_MAX    = 127;
    localparam int SAT_MIN    = -128;
    localparam int PACK_BYTES = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    // Arithmetic shift with optional guard-bit rounding, saturated to a signed byte.
    function automatic logic [7:0] requant_byte(input logic [15:0] d,
                                                input logic [4:0]  s,
                                                input logic        shift_en,
                                                input logic [1:0]  round_mode);
        logic signed [16:0] dx;
        logic signed [16:0] t;
        logic               guard;
        dx    = {d[15], d};
        guard = |(d & (16'h0001 << (s - 5'd1)));
        if (!shift_en || s == 5'd0) begin
            t = dx;
        end else if (s >= 5'd16) begin
            t = {17{d[15]}};
        end else begin
            t = dx >>> s;
            if (round_mode != 2'd0 && guard) t = t + 17'sd1;
        end
        if (t > $signed(17'(SAT_MAX))) begin
            requant_byte = 8'(SAT_MAX);
        end else if (t < $signed(17'(SAT_MIN))) begin
            requant_byte = 8'(SAT_MIN);
        end else begin
            requant_byte = t[7:0];
        end
    endfunction

endpackage

// File: rtl/requant_sched_if.sv
// Config, input-stream and packed-output handshake bundle of the requant sequencer.
interface requant_sched_if #(
    parameter int unsigned LEN_W = 16
) ();

    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [LEN_W-1:0] i_cfg_len;
    logic [4:0]       i_cfg_shift_num;
    logic             i_cfg_shift_en;
    logic [1:0]       i_cfg_round_mode;
    logic             i_dat_valid;
    logic             o_dat_ready;
    logic [15:0]      i_dat;
    logic             o_pack_valid;
    logic             i_pack_ready;
    logic [31:0]      o_pack_data;
    logic             o_pack_last;
    logic             o_done;
    logic             o_busy;

    modport master (
        output i_cfg_valid, i_cfg_len, i_cfg_shift_num, i_cfg_shift_en, i_cfg_round_mode,
        output i_dat_valid, i_dat, i_pack_ready,
        input  o_cfg_ready, o_dat_ready, o_pack_valid, o_pack_data, o_pack_last,
        input  o_done, o_busy
    );

    modport slave (
        input  i_cfg_valid, i_cfg_len, i_cfg_shift_num, i_cfg_shift_en, i_cfg_round_mode,
        input  i_dat_valid, i_dat, i_pack_ready,
        output o_cfg_ready, o_dat_ready, o_pack_valid, o_pack_data, o_pack_last,
        output o_done, o_busy
    );

endinterface

// File: rtl/requant_lane.sv
// One registered shift/round/saturate stage; holds its byte while the consumer is stalled.
module requant_lane
    import npu_requant_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic [15:0] i_dat,
    input  logic [4:0]  i_shift_num,
    input  logic        i_shift_en,
    input  logic [1:0]  i_round_mode,
    input  logic        i_hold,
    output logic        o_valid,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic       valid_q;
    logic [7:0] byte_q;
    logic       last_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
        end else if (!i_hold) begin
            valid_q <= i_valid;
            byte_q  <= requant_byte(i_dat, i_shift_num, i_shift_en, i_round_mode);
            last_q  <= i_last;
        end
    end

    assign o_valid = valid_q;
    assign o_byte  = byte_q;
    assign o_last  = last_q;

endmodule

// File: rtl/requant_sched.sv
// Burst sequencer: captures a layer config, requantizes 16b words through one lane and
// packs four result bytes per 32-bit output word with backpressure on both sides.
module requant_sched
    import npu_requant_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input logic            i_clk,
    input logic            i_rst,
    requant_sched_if.slave bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic [4:0]       shift_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic [1:0]       idx_q;
    logic [23:0]      asm_q, asm_d;
    logic [31:0]      out_data_q, word_d;
    logic             out_valid_q, out_last_q;

    logic       lane_valid, lane_last, lane_hold, lane_adv, completes;
    logic [7:0] lane_byte;
    logic       cfg_hs, dat_ready, dat_hs, in_last, pack_hs;

    assign cfg_hs    = bus.i_cfg_valid && (state_q == IDLE);
    assign dat_ready = (state_q == RUN) && (cnt_q < len_q) && (!lane_valid || !lane_hold);
    assign dat_hs    = bus.i_dat_valid && dat_ready;
    assign in_last   = (cnt_q == len_q - LEN_W'(1));
    assign pack_hs   = out_valid_q && bus.i_pack_ready;
    assign completes = (idx_q == 2'(PACK_BYTES - 1)) || lane_last;
    // Only a word-completing byte needs the output register, and only while it cannot drain.
    assign lane_hold = lane_valid && completes && out_valid_q && !bus.i_pack_ready;
    assign lane_adv  = lane_valid && !lane_hold;

    requant_lane u_lane (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (dat_hs),
        .i_last       (in_last),
        .i_dat        (bus.i_dat),
        .i_shift_num  (shift_q),
        .i_shift_en   (en_q),
        .i_round_mode (mode_q),
        .i_hold       (lane_hold),
        .o_valid      (lane_valid),
        .o_byte       (lane_byte),
        .o_last       (lane_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cfg_hs) state_d = (bus.i_cfg_len == '0) ? DONE : RUN;
            RUN:   if (dat_hs && in_last) state_d = FLUSH;
            FLUSH: if (pack_hs && out_last_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bytes above the current index are never taken from asm_q, so no clearing is needed.
    always_comb begin
        asm_d  = asm_q;
        word_d = '0;
        unique case (idx_q)
            2'd0: begin
                asm_d[7:0] = lane_byte;
                word_d     = {24'h0, lane_byte};
            end
            2'd1: begin
                asm_d[15:8] = lane_byte;
                word_d      = {16'h0, lane_byte, asm_q[7:0]};
            end
            2'd2: begin
                asm_d[23:16] = lane_byte;
                word_d       = {8'h0, lane_byte, asm_q[15:0]};
            end
            default: word_d = {lane_byte, asm_q};
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            shift_q <= '0;
            en_q    <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_hs) begin
                len_q   <= bus.i_cfg_len;
                shift_q <= bus.i_cfg_shift_num;
                en_q    <= bus.i_cfg_shift_en;
                mode_q  <= bus.i_cfg_round_mode;
                cnt_q   <= '0;
            end else if (dat_hs) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (lane_adv && completes) begin
                idx_q       <= '0;
                asm_q       <= '0;
                out_data_q  <= word_d;
                out_last_q  <= lane_last;
                out_valid_q <= 1'b1;
            end else begin
                if (lane_adv) begin
                    idx_q <= idx_q + 2'd1;
                    asm_q <= asm_d;
                end
                if (pack_hs) out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_cfg_ready  = (state_q == IDLE);
    assign bus.o_dat_ready  = dat_ready;
    assign bus.o_pack_valid = out_valid_q;
    assign bus.o_pack_data  = out_data_q;
    assign bus.o_pack_last  = out_last_q;
    assign bus.o_done       = (state_q == DONE);
    assign bus.o_busy       = (state_q != IDLE);

endmodule
